// File: rtl/stream_pacer.sv
// Rate-smoothing stage: buffers bursty nd-strobed samples and re-emits them in order,
// at most once every SPACING cycles. Optional debug message port under PACER_MSG_EN.
module stream_pacer #(
    parameter int WIDTH     = 32,
    parameter int MWIDTH    = 1,
    parameter int LOG_DEPTH = 4,
    parameter int SPACING   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_nd,
    input  logic [MWIDTH-1:0] in_m,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_nd,
    output logic [MWIDTH-1:0] out_m,
    output logic              error
`ifdef PACER_MSG_EN
    ,
    output logic [WIDTH-1:0]  msg,
    output logic              msg_nd
`endif
);

    localparam int DEPTH = 2 ** LOG_DEPTH;
    localparam int EW    = MWIDTH + WIDTH;
    localparam int GW    = (SPACING > 1) ? $clog2(SPACING) : 1;
    localparam logic [GW-1:0]        GAP_RELOAD = GW'(SPACING - 1);
    localparam logic [LOG_DEPTH:0]   COUNT_FULL = (LOG_DEPTH + 1)'(DEPTH);

    logic [EW-1:0]        r_mem [DEPTH];
    logic [LOG_DEPTH-1:0] r_wptr;
    logic [LOG_DEPTH-1:0] r_rptr;
    logic [LOG_DEPTH:0]   r_count;
    logic [GW-1:0]        r_gap;
    logic [WIDTH-1:0]     r_out_data;
    logic                 r_out_nd;
    logic [MWIDTH-1:0]    r_out_m;
    logic                 r_error;

    logic                 w_full;
    logic                 w_wr;
    logic                 w_rd;
    logic [EW-1:0]        w_head;
    logic [LOG_DEPTH:0]   w_count_nxt;

    assign w_full = (r_count == COUNT_FULL);
    assign w_wr   = in_nd & ~w_full;
    assign w_rd   = (r_count != '0) & (r_gap == '0);
    assign w_head = r_mem[r_rptr];

    // Occupancy update from the write/read strobes of this cycle.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_rd})
            2'b10:   w_count_nxt = r_count + (LOG_DEPTH + 1)'(1);
            2'b01:   w_count_nxt = r_count - (LOG_DEPTH + 1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Sample storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= {in_m, in_data};
        end else begin
            r_mem[r_wptr] <= r_mem[r_wptr];
        end
    end

    // Pointers, occupancy, pacing gap, registered outputs and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_gap      <= '0;
            r_out_data <= '0;
            r_out_nd   <= 1'b0;
            r_out_m    <= '0;
            r_error    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (w_wr) begin
                r_wptr <= r_wptr + LOG_DEPTH'(1);
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_rd) begin
                r_out_data <= w_head[WIDTH-1:0];
                r_out_m    <= w_head[EW-1:WIDTH];
                r_out_nd   <= 1'b1;
                r_rptr     <= r_rptr + LOG_DEPTH'(1);
                r_gap      <= GAP_RELOAD;
            end else begin
                r_out_nd <= 1'b0;
                if (r_gap != '0) begin
                    r_gap <= r_gap - GW'(1);
                end else begin
                    r_gap <= r_gap;
                end
            end
            // A full buffer drops the sample even if a read frees a slot this cycle.
            if (in_nd && w_full) begin
                r_error <= 1'b1;
            end else begin
                r_error <= r_error;
            end
        end
    end

    assign out_data = r_out_data;
    assign out_nd   = r_out_nd;
    assign out_m    = r_out_m;
    assign error    = r_error;

`ifdef PACER_MSG_EN
    logic [WIDTH-1:0] r_msg;
    logic             r_msg_nd;

    // Report only the first drop after reset, on the edge where error rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_msg    <= '0;
            r_msg_nd <= 1'b0;
        end else if (in_nd && w_full && !r_error) begin
            r_msg    <= in_data;
            r_msg_nd <= 1'b1;
        end else begin
            r_msg    <= r_msg;
            r_msg_nd <= 1'b0;
        end
    end

    assign msg    = r_msg;
    assign msg_nd = r_msg_nd;
`endif

endmodule

// File: tb/tb_stream_pacer.sv
// Scoreboard bench for stream_pacer: five instances with different parameters share one
// timeline; stimulus pushes hand-computed (cycle, data, meta) expectations, a monitor pops.
module tb_stream_pacer;

    typedef struct {
        int          c;
        logic [31:0] d;
        logic        m;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        rst_d;
    logic [31:0] din   [5];
    logic        ndin  [5];
    logic        min   [5];
    logic [31:0] dout  [5];
    logic        ndout [5];
    logic        mout  [5];
    logic        err   [5];
`ifdef PACER_MSG_EN
    logic [31:0] msgo  [5];
    logic        msgnd [5];
    int          msg_cnt = 0;
`endif

    exp_t q [5][$];
    int   cyc     = 0;
    bit   running = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stream_pacer u_a (
        .clk(clk), .rst(rst), .in_data(din[0]), .in_nd(ndin[0]), .in_m(min[0]),
        .out_data(dout[0]), .out_nd(ndout[0]), .out_m(mout[0]), .error(err[0])
`ifdef PACER_MSG_EN
        , .msg(msgo[0]), .msg_nd(msgnd[0])
`endif
    );

    stream_pacer #(.SPACING(3)) u_b (
        .clk(clk), .rst(rst), .in_data(din[1]), .in_nd(ndin[1]), .in_m(min[1]),
        .out_data(dout[1]), .out_nd(ndout[1]), .out_m(mout[1]), .error(err[1])
`ifdef PACER_MSG_EN
        , .msg(msgo[1]), .msg_nd(msgnd[1])
`endif
    );

    stream_pacer #(.LOG_DEPTH(2), .SPACING(16)) u_c (
        .clk(clk), .rst(rst), .in_data(din[2]), .in_nd(ndin[2]), .in_m(min[2]),
        .out_data(dout[2]), .out_nd(ndout[2]), .out_m(mout[2]), .error(err[2])
`ifdef PACER_MSG_EN
        , .msg(msgo[2]), .msg_nd(msgnd[2])
`endif
    );

    stream_pacer #(.LOG_DEPTH(2), .SPACING(16)) u_d (
        .clk(clk), .rst(rst || rst_d), .in_data(din[3]), .in_nd(ndin[3]), .in_m(min[3]),
        .out_data(dout[3]), .out_nd(ndout[3]), .out_m(mout[3]), .error(err[3])
`ifdef PACER_MSG_EN
        , .msg(msgo[3]), .msg_nd(msgnd[3])
`endif
    );

    stream_pacer #(.SPACING(1)) u_e (
        .clk(clk), .rst(rst), .in_data(din[4]), .in_nd(ndin[4]), .in_m(min[4]),
        .out_data(dout[4]), .out_nd(ndout[4]), .out_m(mout[4]), .error(err[4])
`ifdef PACER_MSG_EN
        , .msg(msgo[4]), .msg_nd(msgnd[4])
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int i, input int c, input logic [31:0] d, input logic m);
        exp_t e;
        e.c = c;
        e.d = d;
        e.m = m;
        q[i].push_back(e);
    endtask

    // Monitor: pop and compare on every out_nd, plus point checks of held state.
    always @(negedge clk) begin
        if (running) begin
            for (int i = 0; i < 5; i++) begin
                if (ndout[i]) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("unexpected_nd_dut%0d", i), dout[i], 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = q[i].pop_front();
                        chk($sformatf("out_cycle_dut%0d", i), 32'(cyc), 32'(e.c));
                        chk($sformatf("out_data_dut%0d", i), dout[i], e.d);
                        chk($sformatf("out_m_dut%0d", i), 32'(mout[i]), 32'(e.m));
                    end
                end
            end
            if (cyc == 0) begin
                chk("reset_out_nd", 32'(ndout[0]), 32'd0);
                chk("reset_out_data", dout[0], 32'd0);
                chk("reset_out_m", 32'(mout[0]), 32'd0);
                chk("reset_error", 32'(err[0]), 32'd0);
            end
            if (cyc == 10) chk("hold_out_data_a", dout[0], 32'h1234);
            if (cyc == 5)  chk("error_before_drop", 32'(err[2]), 32'd0);
            if (cyc == 6)  chk("error_on_drop", 32'(err[2]), 32'd1);
            if (cyc == 19) chk("hold_out_data_d", dout[3], 32'd2);
            if (cyc == 21) begin
                chk("midrst_out_nd", 32'(ndout[3]), 32'd0);
                chk("midrst_out_data", dout[3], 32'd0);
                chk("midrst_error", 32'(err[3]), 32'd0);
            end
            if (cyc == 75) begin
                chk("error_sticky", 32'(err[2]), 32'd1);
                chk("error_a", 32'(err[0]), 32'd0);
                chk("error_b", 32'(err[1]), 32'd0);
                chk("error_d", 32'(err[3]), 32'd0);
                chk("error_e", 32'(err[4]), 32'd0);
            end
`ifdef PACER_MSG_EN
            if (msgnd[2]) begin
                msg_cnt++;
                chk("msg_cycle", 32'(cyc), 32'd6);
                chk("msg_data", msgo[2], 32'd6);
            end
`endif
        end
    end

    initial begin
        rst   = 1'b1;
        rst_d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din[i]  = 32'd0;
            ndin[i] = 1'b0;
            min[i]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        running = 1'b1;
        for (int c = 0; c <= 75; c++) begin
            cyc = c;
            for (int i = 0; i < 5; i++) begin
                ndin[i] = 1'b0;
                din[i]  = 32'd0;
                min[i]  = 1'b0;
            end
            rst_d = (c == 20);
            if (c == 0) begin
                din[0] = 32'h1234; min[0] = 1'b1; ndin[0] = 1'b1;
                push(0, 2, 32'h1234, 1'b1);
            end
            if (c < 5) begin
                din[1] = 32'(c + 1); ndin[1] = 1'b1;
                push(1, 2 + 3 * c, 32'(c + 1), 1'b0);
            end
            if (c < 8) begin
                din[2] = 32'(c + 1); min[2] = c[0]; ndin[2] = 1'b1;
                din[3] = 32'(c + 1); min[3] = c[0]; ndin[3] = 1'b1;
                if (c < 5) push(2, 2 + 16 * c, 32'(c + 1), c[0]);
                if (c < 2) push(3, 2 + 16 * c, 32'(c + 1), c[0]);
            end
            if (c == 30) begin
                din[3] = 32'h55; ndin[3] = 1'b1;
                push(3, 32, 32'h55, 1'b0);
            end
            if (c < 20) begin
                din[4] = 32'(c + 1); ndin[4] = 1'b1;
                push(4, c + 2, 32'(c + 1), 1'b0);
            end
            @(posedge clk);
            #1;
        end
        running = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("pending_outputs_dut%0d", i), 32'(q[i].size()), 32'd0);
        end
`ifdef PACER_MSG_EN
        chk("msg_pulse_count", 32'(msg_cnt), 32'd1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
